// File: rtl/cache_controller.sv
// cache_controller: 4-way set-associative, write-back, write-allocate L1 data cache with true-LRU.
// Optional CC_CRITICAL_WORD_FIRST_EN makes line fills start at the requested word and wrap.
module cache_controller #(
  parameter int ADR_WIDTH     = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int WORD_OFFSET   = 2,
  parameter int DATAMEM_WIDTH = DATA_WIDTH << WORD_OFFSET,
  parameter int INDEX_WIDTH   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_cpu2cc,
  input  logic [ADR_WIDTH-1:0]     adr_cpu2cc,
  input  logic [DATA_WIDTH-1:0]    dat_cpu2cc,
  input  logic                     rdwr_cpu2cc,
  output logic                     ack_cc2cpu,
  output logic [DATA_WIDTH-1:0]    dat_cc2cpu,
  output logic                     req_cc2mem,
  output logic [ADR_WIDTH-1:0]     adr_cc2mem,
  input  logic                     ack_mem2cc,
  input  logic [DATA_WIDTH-1:0]    dat_mem2cc,
  output logic [DATA_WIDTH-1:0]    dat_mem2mshr,
  output logic [WORD_OFFSET-1:0]   word_mem2mshr,
  output logic [DATAMEM_WIDTH-1:0] dat_cc2mshr
);
  // Handshakes: req_cpu2cc is a level held until the one-cycle ack_cc2cpu pulse; WAIT blocks a
  // second ack until req drops. req_cc2mem is a level and every ack_mem2cc pulse consumes one beat.
  localparam int TAG_WIDTH = ADR_WIDTH - INDEX_WIDTH - WORD_OFFSET - 2;
  localparam int WAYS      = 4;
  localparam int SETS      = 1 << INDEX_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_EVICT, S_FILL, S_REFILL, S_RESP, S_WAIT
  } state_t;

  state_t state, state_next;

  logic [DATAMEM_WIDTH-1:0] data_mem  [WAYS][SETS];
  logic [TAG_WIDTH-1:0]     tag_mem   [WAYS][SETS];
  logic [WAYS-1:0]          valid_mem [SETS];
  logic [WAYS-1:0]          dirty_mem [SETS];
  logic [1:0]               age_mem   [SETS][WAYS];

  logic [ADR_WIDTH-3:0]     adr_r;
  logic [DATA_WIDTH-1:0]    dat_r;
  logic                     rdwr_r;
  logic [1:0]               way_r;
  logic [WORD_OFFSET-1:0]   beat;
  logic [DATAMEM_WIDTH-1:0] fill_buf;

  logic [TAG_WIDTH-1:0]     tag_r;
  logic [INDEX_WIDTH-1:0]   index_r;
  logic [WORD_OFFSET-1:0]   word_r;
  logic [WORD_OFFSET-1:0]   fill_word;
  logic                     hit, inv_found;
  logic [1:0]               hit_way, inv_way, lru_way, victim_way, touch_way;
  logic                     lru_touch;
  logic [DATAMEM_WIDTH-1:0] hit_line;
  logic                     unused_adr_bits;

  assign unused_adr_bits = ^adr_cpu2cc[1:0];
  assign tag_r   = adr_r[ADR_WIDTH-3 -: TAG_WIDTH];
  assign index_r = adr_r[WORD_OFFSET +: INDEX_WIDTH];
  assign word_r  = adr_r[WORD_OFFSET-1:0];

`ifdef CC_CRITICAL_WORD_FIRST_EN
  assign fill_word = beat + word_r;
`else
  assign fill_word = beat;
`endif

  // Downward scan so the lowest-numbered matching/invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = 2'd0;
    inv_found = 1'b0;
    inv_way   = 2'd0;
    lru_way   = 2'd0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_mem[index_r][w] && (tag_mem[w][index_r] == tag_r)) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
      if (!valid_mem[index_r][w]) begin
        inv_found = 1'b1;
        inv_way   = 2'(w);
      end
      if (age_mem[index_r][w] == 2'd3) lru_way = 2'(w);
    end
    victim_way = inv_found ? inv_way : lru_way;
    hit_line   = data_mem[hit_way][index_r];
  end

  assign lru_touch = ((state == S_LOOKUP) && hit) || (state == S_REFILL);
  assign touch_way = (state == S_LOOKUP) ? hit_way : way_r;

  function automatic logic [1:0] next_age(input logic [1:0] cur, input logic [1:0] acc_age,
                                          input logic is_acc);
    if (is_acc)              return 2'd0;
    else if (cur < acc_age)  return cur + 2'd1;
    else                     return cur;
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (req_cpu2cc) state_next = S_LOOKUP;
      S_LOOKUP: state_next = hit ? S_RESP : S_EVICT;
      S_EVICT:  state_next = S_FILL;
      S_FILL:   if (ack_mem2cc && (&beat)) state_next = S_REFILL;
      S_REFILL: state_next = S_RESP;
      S_RESP:   state_next = S_WAIT;
      S_WAIT:   if (!req_cpu2cc) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign ack_cc2cpu = (state == S_RESP);
  assign req_cc2mem = (state == S_FILL);
  assign adr_cc2mem = (state == S_FILL) ? {tag_r, index_r, fill_word, 2'b00} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      adr_r         <= '0;
      dat_r         <= '0;
      rdwr_r        <= 1'b0;
      way_r         <= 2'd0;
      beat          <= '0;
      dat_cc2cpu    <= '0;
      dat_cc2mshr   <= '0;
      dat_mem2mshr  <= '0;
      word_mem2mshr <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_mem[s][w] <= 2'(w);
      end
    end else begin
      state <= state_next;
      if (lru_touch) begin
        for (int w = 0; w < WAYS; w++)
          age_mem[index_r][w] <= next_age(age_mem[index_r][w], age_mem[index_r][touch_way],
                                          2'(w) == touch_way);
      end
      case (state)
        S_IDLE: if (req_cpu2cc) begin
          adr_r  <= adr_cpu2cc[ADR_WIDTH-1:2];
          dat_r  <= dat_cpu2cc;
          rdwr_r <= rdwr_cpu2cc;
        end
        S_LOOKUP: begin
          way_r <= hit ? hit_way : victim_way;
          if (hit) dat_cc2cpu <= rdwr_r ? dat_r : hit_line[word_r*DATA_WIDTH +: DATA_WIDTH];
        end
        S_EVICT: begin
          beat <= '0;
          if (valid_mem[index_r][way_r] && dirty_mem[index_r][way_r])
            dat_cc2mshr <= data_mem[way_r][index_r];
        end
        S_FILL: if (ack_mem2cc) begin
          beat          <= beat + 1'b1;
          dat_mem2mshr  <= dat_mem2cc;
          word_mem2mshr <= fill_word;
        end
        S_REFILL: begin
          valid_mem[index_r][way_r] <= 1'b1;
          dirty_mem[index_r][way_r] <= 1'b0;
          dat_cc2cpu <= rdwr_r ? dat_r : fill_buf[word_r*DATA_WIDTH +: DATA_WIDTH];
        end
        S_RESP: if (rdwr_r) dirty_mem[index_r][way_r] <= 1'b1;
        default: ;
      endcase
    end
  end

  // Data and tag storage are never reset; validity alone decides what is live.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_FILL) && ack_mem2cc)
      fill_buf[fill_word*DATA_WIDTH +: DATA_WIDTH] <= dat_mem2cc;
    if (!rst && (state == S_REFILL)) begin
      data_mem[way_r][index_r] <= fill_buf;
      tag_mem[way_r][index_r]  <= tag_r;
    end
    if (!rst && (state == S_RESP) && rdwr_r)
      data_mem[way_r][index_r][word_r*DATA_WIDTH +: DATA_WIDTH] <= dat_r;
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed CPU accesses, a reactive memory responder
// and an expected-data queue checked by a monitor on every ack_cc2cpu.
module tb_cache_controller;
  logic         clk = 1'b0;
  logic         rst;
  logic         req_cpu2cc;
  logic [31:0]  adr_cpu2cc;
  logic [31:0]  dat_cpu2cc;
  logic         rdwr_cpu2cc;
  logic         ack_cc2cpu;
  logic [31:0]  dat_cc2cpu;
  logic         req_cc2mem;
  logic [31:0]  adr_cc2mem;
  logic         ack_mem2cc;
  logic [31:0]  dat_mem2cc;
  logic [31:0]  dat_mem2mshr;
  logic [1:0]   word_mem2mshr;
  logic [127:0] dat_cc2mshr;

  cache_controller dut (
    .clk(clk), .rst(rst),
    .req_cpu2cc(req_cpu2cc), .adr_cpu2cc(adr_cpu2cc), .dat_cpu2cc(dat_cpu2cc),
    .rdwr_cpu2cc(rdwr_cpu2cc), .ack_cc2cpu(ack_cc2cpu), .dat_cc2cpu(dat_cc2cpu),
    .req_cc2mem(req_cc2mem), .adr_cc2mem(adr_cc2mem), .ack_mem2cc(ack_mem2cc),
    .dat_mem2cc(dat_mem2cc), .dat_mem2mshr(dat_mem2mshr), .word_mem2mshr(word_mem2mshr),
    .dat_cc2mshr(dat_cc2mshr)
  );

  // Clock/reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [31:0] fill_line[4];
  logic [31:0] fill_base;
  logic [1:0]  req_word_tb;
  logic [1:0]  exp_word;
  int          mem_beats;
  int          last_mem_cyc;
  logic        stray_req;
  logic        chk_pending;
  logic [31:0] chk_dat;
  logic [1:0]  chk_word;
  bit          got;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Memory responder: acks every other cycle while req_cc2mem is high, checks beat order.
  always begin
    @(posedge clk); #1;
    if (ack_mem2cc) begin
      ack_mem2cc = 1'b0;
      if (chk_pending && !rst) begin
        check("mshr_fill_dat", 128'(dat_mem2mshr), 128'(chk_dat));
        check("mshr_fill_word", 128'(word_mem2mshr), 128'(chk_word));
      end
      chk_pending = 1'b0;
    end else if (req_cc2mem) begin
`ifdef CC_CRITICAL_WORD_FIRST_EN
      exp_word = 2'(mem_beats) + req_word_tb;
`else
      exp_word = 2'(mem_beats);
`endif
      check("fill_adr", 128'(adr_cc2mem), 128'(fill_base | {28'h0, exp_word, 2'b00}));
      dat_mem2cc   = fill_line[adr_cc2mem[3:2]];
      ack_mem2cc   = 1'b1;
      chk_pending  = 1'b1;
      chk_dat      = fill_line[adr_cc2mem[3:2]];
      chk_word     = adr_cc2mem[3:2];
      mem_beats++;
      last_mem_cyc = cyc;
    end else if (stray_req) begin
      dat_mem2cc  = 32'hDEADBEEF;
      ack_mem2cc  = 1'b1;
      chk_pending = 1'b0;
      stray_req   = 1'b0;
    end
  end

  // Monitor / scoreboard: every CPU ack must match the head of the expected queue.
  always @(negedge clk) begin
    if (ack_cc2cpu === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got ack with data %h, required no ack", dat_cc2cpu);
      end else begin
        mon_exp = exp_q.pop_front();
        check("cpu_data", 128'(dat_cc2cpu), 128'(mon_exp));
      end
    end
  end

  // Driver: one CPU access, with latency and memory-traffic checks.
  task automatic cpu_access(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic rw, input logic [31:0] exp_data, input logic exp_miss);
    int start;
    bit seen;
    mem_beats   = 0;
    fill_base   = {addr[31:4], 4'h0};
    req_word_tb = addr[3:2];
    exp_q.push_back(exp_data);
    @(posedge clk); #1;
    req_cpu2cc  = 1'b1;
    adr_cpu2cc  = addr;
    dat_cpu2cc  = wdata;
    rdwr_cpu2cc = rw;
    start       = cyc;
    seen        = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (ack_cc2cpu) begin
        seen = 1'b1;
        break;
      end
    end
    req_cpu2cc = 1'b0;
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no ack in 60 cycles, required ack", name);
      exp_q.delete();
    end else begin
      if (exp_miss) check({name, "_miss_latency"}, 128'(cyc - last_mem_cyc), 128'd2);
      else          check({name, "_hit_latency"}, 128'(cyc - start), 128'd2);
      check({name, "_mem_beats"}, 128'(mem_beats), exp_miss ? 128'd4 : 128'd0);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_cpu2cc = 1'b0; adr_cpu2cc = '0; dat_cpu2cc = '0; rdwr_cpu2cc = 1'b0;
    ack_mem2cc = 1'b0; dat_mem2cc = '0; stray_req = 1'b0; chk_pending = 1'b0;
    mem_beats = 0; last_mem_cyc = 0; fill_base = '0; req_word_tb = '0;
    for (int i = 0; i < 4; i++) fill_line[i] = 32'hFFFFFFFF;
    repeat (3) @(posedge clk); #1;
    check("rst_ack", 128'(ack_cc2cpu), 128'd0);
    check("rst_req_mem", 128'(req_cc2mem), 128'd0);
    check("rst_adr_mem", 128'(adr_cc2mem), 128'd0);
    check("rst_dat_cpu", 128'(dat_cc2cpu), 128'd0);
    check("rst_mshr_dat", 128'(dat_mem2mshr), 128'd0);
    check("rst_mshr_word", 128'(word_mem2mshr), 128'd0);
    check("rst_victim", dat_cc2mshr, 128'd0);
    rst = 1'b0;

    stray_req = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("stray_ack_ignored", 128'(dat_mem2mshr), 128'd0);

    cpu_access("miss_w0", 32'hFF07BD08, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b1);
    cpu_access("miss_w1", 32'hA5555108, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b1);
    cpu_access("miss_w2", 32'hD500AD08, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b1);
    cpu_access("miss_w3", 32'hFFFFFD08, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b1);
    cpu_access("rd_hit_w0", 32'hFF07BD08, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0);
    cpu_access("wr_hit_w3", 32'hFFFFFD08, 32'hAA8AAAA4, 1'b1, 32'hAA8AAAA4, 1'b0);
    cpu_access("rd_back_w3", 32'hFFFFFD08, 32'h0, 1'b0, 32'hAA8AAAA4, 1'b0);
    cpu_access("hit_w0", 32'hFF07BD08, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0);
    cpu_access("hit_w3", 32'hFFFFFD08, 32'h0, 1'b0, 32'hAA8AAAA4, 1'b0);
    cpu_access("hit_w2", 32'hD500AD08, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0);

    // Ages now 2,3,0,1: the write miss must replace clean way1.
    cpu_access("wr_miss_w1", 32'h5F57ED08, 32'hAAAAAAAA, 1'b1, 32'hAAAAAAAA, 1'b1);
    check("clean_victim_unchanged", dat_cc2mshr, 128'd0);
    cpu_access("rd_merged_w2", 32'h5F57ED08, 32'h0, 1'b0, 32'hAAAAAAAA, 1'b0);
    cpu_access("rd_merged_w0", 32'h5F57ED00, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0);

    cpu_access("wr_hit_w0", 32'hFF07BD08, 32'h12345678, 1'b1, 32'h12345678, 1'b0);
    fill_line[0] = 32'h0A0A0A00; fill_line[1] = 32'h0A0A0A01;
    fill_line[2] = 32'h0A0A0A02; fill_line[3] = 32'h0A0A0A03;
    cpu_access("rd_miss_dirty", 32'h3A82AD08, 32'h0, 1'b0, 32'h0A0A0A02, 1'b1);
    check("dirty_victim_line", dat_cc2mshr,
          {32'hFFFFFFFF, 32'hAA8AAAA4, 32'hFFFFFFFF, 32'hFFFFFFFF});
    cpu_access("rd_hit_word1", 32'h3A82AD04, 32'h0, 1'b0, 32'h0A0A0A01, 1'b0);
    for (int i = 0; i < 4; i++) fill_line[i] = 32'hFFFFFFFF;
    cpu_access("rd_evicted", 32'hFFFFFD08, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b1);
    check("clean_victim_keeps_old", dat_cc2mshr,
          {32'hFFFFFFFF, 32'hAA8AAAA4, 32'hFFFFFFFF, 32'hFFFFFFFF});

    // Reset during the second fill beat.
    fill_line[0] = 32'h11111111; fill_line[1] = 32'h22222222;
    fill_line[2] = 32'h33333333; fill_line[3] = 32'h44444444;
    mem_beats = 0; fill_base = 32'h00001230; req_word_tb = 2'd0;
    @(posedge clk); #1;
    req_cpu2cc = 1'b1; adr_cpu2cc = 32'h00001230; rdwr_cpu2cc = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (mem_beats == 2) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL abort_reach_beat2: got %0d beats, required 2", mem_beats);
    end
    rst = 1'b1;
    req_cpu2cc = 1'b0;
    @(posedge clk); #1;
    check("abort_req_mem", 128'(req_cc2mem), 128'd0);
    check("abort_ack_cpu", 128'(ack_cc2cpu), 128'd0);
    check("abort_mshr_dat", 128'(dat_mem2mshr), 128'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    cpu_access("post_rst_miss", 32'h00001230, 32'h0, 1'b0, 32'h11111111, 1'b1);
    cpu_access("post_rst_invalid", 32'hFF07BD08, 32'h0, 1'b0, 32'h33333333, 1'b1);

    repeat (5) @(posedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
